// File: rtl/mem_xfer_engine.sv
// Byte-block copy engine mastering the memory system bus.
// Optional running byte checksum output: define XFER_CHECKSUM_EN.
module mem_xfer_engine #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       src_addr,
  input  logic [7:0]       dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef XFER_CHECKSUM_EN
  ,
  output logic [7:0]       checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    WR,
    DONE
  } state_t;

  state_t           state;
  logic [7:0]       src;
  logic [7:0]       dst;
  logic [LEN_W-1:0] remaining;

  function automatic logic writable(
    input logic [7:0] a
  );
    return (a >= 8'h80) && (a <= 8'hE1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      src       <= 8'h00;
      dst       <= 8'h00;
      remaining <= '0;
      mem_addr  <= 8'h00;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef XFER_CHECKSUM_EN
      checksum  <= 8'h00;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done   <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= length;
            err       <= 1'b0;
`ifdef XFER_CHECKSUM_EN
            checksum  <= 8'h00;
`endif
            if (length != '0) begin
              state    <= RD;
              mem_addr <= src_addr;
              busy     <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RD: begin
          state <= WAIT;
        end
        WAIT: begin
          state     <= WR;
          mem_wdata <= mem_rdata;
          // strobe only legal targets; WR reads mem_we back as the verdict
          if (writable(dst)) begin
            mem_addr <= dst;
            mem_we   <= 1'b1;
          end
        end
        WR: begin
          mem_we <= 1'b0;
          if (mem_we) begin
`ifdef XFER_CHECKSUM_EN
            checksum  <= checksum + mem_wdata;
`endif
            remaining <= remaining - LEN_W'(1);
            src       <= src + 8'd1;
            dst       <= dst + 8'd1;
            if (remaining == LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= RD;
              mem_addr <= src + 8'd1;
            end
          end else begin
            err   <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done   <= 1'b0;
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xfer_engine.sv
// Directed bench for mem_xfer_engine with a small memory system model.
// Checksum steps compile only with XFER_CHECKSUM_EN.
module tb_mem_xfer_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src_addr = 8'h00;
  logic [7:0] dst_addr = 8'h00;
  logic [7:0] length = 8'h00;
  logic [7:0] mem_rdata;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;
  logic       err;
`ifdef XFER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  logic [7:0] rom [0:127];
  logic [7:0] ram [128:223];
  logic [7:0] port_out_00 = 8'h00;
  logic [7:0] port_out_01 = 8'h00;
  logic [7:0] port_in_00 = 8'h00;
  logic [7:0] port_in_01 = 8'h00;
  int         we_cnt = 0;
  int         we_base;
  int         total = 0;
  int         bad = 0;

  mem_xfer_engine #(.LEN_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef XFER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  // memory system: one-cycle registered read, write at the strobe edge
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt <= we_cnt + 1;
      if (mem_addr >= 8'h80 && mem_addr <= 8'hDF)
        ram[mem_addr] <= mem_wdata;
      else if (mem_addr == 8'hE0)
        port_out_00 <= mem_wdata;
      else if (mem_addr == 8'hE1)
        port_out_01 <= mem_wdata;
    end
    if (mem_addr < 8'h80)
      mem_rdata <= rom[mem_addr[6:0]];
    else if (mem_addr <= 8'hDF)
      mem_rdata <= ram[mem_addr];
    else if (mem_addr == 8'hF0)
      mem_rdata <= port_in_00;
    else if (mem_addr == 8'hF1)
      mem_rdata <= port_in_01;
    else
      mem_rdata <= 8'h00;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // returns inside the cycle that begins at the accepting edge E0
  task automatic go(
    input logic [7:0] s,
    input logic [7:0] d,
    input logic [7:0] l
  );
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++)
      rom[i] = 8'(i * 7 + 3);
    rom[32] = 8'h01;
    rom[33] = 8'hFF;
    rom[34] = 8'h10;

    cyc(2);
    chk("rst_addr", 32'(mem_addr), 32'h00);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    cyc(1);

    // ROM 0x10..0x13 -> RAM 0x80..0x83
    we_base = we_cnt;
    go(8'h10, 8'h80, 8'd4);
    chk("cp_busy0", 32'(busy), 32'h1);
    chk("cp_addr0", 32'(mem_addr), 32'h10);
    cyc(2);
    chk("cp_we2", 32'(mem_we), 32'h1);
    chk("cp_waddr2", 32'(mem_addr), 32'h80);
    chk("cp_wdata2", 32'(mem_wdata), 32'h73);
    cyc(1);
    chk("cp_addr3", 32'(mem_addr), 32'h11);
    chk("cp_we3", 32'(mem_we), 32'h0);
    cyc(8);
    chk("cp_done11", 32'(done), 32'h0);
    cyc(1);
    chk("cp_done12", 32'(done), 32'h1);
    chk("cp_busy12", 32'(busy), 32'h0);
    chk("cp_err12", 32'(err), 32'h0);
    chk("cp_ram80", 32'(ram[8'h80]), 32'h73);
    chk("cp_ram81", 32'(ram[8'h81]), 32'h7A);
    chk("cp_ram82", 32'(ram[8'h82]), 32'h81);
    chk("cp_ram83", 32'(ram[8'h83]), 32'h88);
    chk("cp_wecnt", 32'(we_cnt - we_base), 32'd4);
    cyc(1);
    chk("cp_done13", 32'(done), 32'h0);

    // input port 00 -> output port 01
    port_in_00 = 8'h5A;
    go(8'hF0, 8'hE1, 8'd1);
    cyc(2);
    chk("pt_waddr", 32'(mem_addr), 32'hE1);
    chk("pt_wdata", 32'(mem_wdata), 32'h5A);
    cyc(1);
    chk("pt_done3", 32'(done), 32'h1);
    chk("pt_out01", 32'(port_out_01), 32'h5A);
    cyc(1);

    // zero length
    we_base = we_cnt;
    go(8'h10, 8'h90, 8'd0);
    chk("z_done0", 32'(done), 32'h1);
    chk("z_busy0", 32'(busy), 32'h0);
    cyc(1);
    chk("z_done1", 32'(done), 32'h0);
    chk("z_busy1", 32'(busy), 32'h0);
    chk("z_wecnt", 32'(we_cnt - we_base), 32'd0);

    // RAM top edge into both output ports
    go(8'h10, 8'hDF, 8'd3);
    cyc(9);
    chk("edge_done", 32'(done), 32'h1);
    chk("edge_err", 32'(err), 32'h0);
    chk("edge_ramdf", 32'(ram[8'hDF]), 32'h73);
    chk("edge_out00", 32'(port_out_00), 32'h7A);
    chk("edge_out01", 32'(port_out_01), 32'h81);
    cyc(1);

    // ROM destination is rejected
    we_base = we_cnt;
    go(8'h10, 8'h7E, 8'd2);
    cyc(2);
    chk("il_we2", 32'(mem_we), 32'h0);
    cyc(1);
    chk("il_done3", 32'(done), 32'h1);
    chk("il_err3", 32'(err), 32'h1);
    chk("il_busy3", 32'(busy), 32'h0);
    cyc(1);
    chk("il_errhold", 32'(err), 32'h1);
    chk("il_wecnt", 32'(we_cnt - we_base), 32'd0);

    // reset during byte 2 wait, start while busy ignored
    we_base = we_cnt;
    go(8'h10, 8'h90, 8'd4);
    chk("ab_errclr", 32'(err), 32'h0);
    src_addr = 8'h00;
    dst_addr = 8'hA0;
    length   = 8'd1;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
    cyc(1);
    chk("ab_waddr2", 32'(mem_addr), 32'h90);
    cyc(1);
    chk("ab_addr3", 32'(mem_addr), 32'h11);
    cyc(4);
    chk("ab_addr7", 32'(mem_addr), 32'h12);
    reset = 1'b0;
    cyc(1);
    chk("ab_addr", 32'(mem_addr), 32'h00);
    chk("ab_we", 32'(mem_we), 32'h0);
    chk("ab_wdata", 32'(mem_wdata), 32'h00);
    chk("ab_busy", 32'(busy), 32'h0);
    chk("ab_done", 32'(done), 32'h0);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    chk("ab_wecnt", 32'(we_cnt - we_base), 32'd2);
    chk("ab_ram90", 32'(ram[8'h90]), 32'h73);
    chk("ab_ram91", 32'(ram[8'h91]), 32'h7A);

`ifdef XFER_CHECKSUM_EN
    go(8'h20, 8'hA8, 8'd3);
    chk("cs_clr", 32'(checksum), 32'h00);
    cyc(9);
    chk("cs_done", 32'(done), 32'h1);
    chk("cs_sum", 32'(checksum), 32'h10);
    cyc(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
